scr_frame_ctrl: RTL and testbench

//  Frame-level controller for the 70-bit, 12-bit/cycle parallel scrambler.
//  - Owns the LFSR state register and seeds it per frame.
//  - Accepts 12-bit words with valid/ready and advances the state 12 steps per accepted word.
//  - Emits the scrambled words through a 2-entry skid buffer with frame markers.
//  - Sits between the framer (upstream) and the serializer (downstream).

---
 rtl/scr_pkg.sv | 38 +++
 rtl/scr_step_nb.sv | 25 ++
 rtl/scr_frame_ctrl.sv | 133 +++++++++++++
 tb/tb_scr_frame_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr_pkg.sv
// Shared constants, tap list, FSM state and skid-entry types for the 70-bit / 12-bit-per-cycle scrambler.
// Build option: define SCR_BYPASS_EN to add the per-word bypass input on scr_frame_ctrl.
package scr_pkg;

   localparam int unsigned SW    = 70;
   localparam int unsigned NB    = 12;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned NTAPS = 5;

   localparam logic [SW-1:0] SEED_RST = {SW{1'b1}};

   localparam int unsigned TAPS [NTAPS] = '{30, 34, 43, 58, 63};

   // Feedback positions as a mask so one step is a shift plus a masked XOR
   function automatic logic [SW-1:0] tap_mask();
      logic [SW-1:0] m;
      m = '0;
      for (int unsigned t = 0; t < NTAPS; t++) begin
         m[7'(TAPS[t])] = 1'b1;
      end
      return m;
   endfunction

   localparam logic [SW-1:0] TAP_MASK = tap_mask();

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fsm_t;

   typedef struct packed {
      logic [NB-1:0] data;
      logic          sof;
      logic          eof;
   } word_t;

endpackage

// File: rtl/scr_step_nb.sv
// Combinational NB-step LFSR advance; bit 0 of the word is scrambled first.
module scr_step_nb
   import scr_pkg::*;
(
   input  logic [SW-1:0] state,
   input  logic [NB-1:0] in_data,
   output logic [SW-1:0] next_state,
   output logic [NB-1:0] scr_data
);

   always_comb begin : step
      logic [SW-1:0] s;
      logic          msb;
      s        = state;
      msb      = 1'b0;
      scr_data = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         msb         = s[SW-1];
         scr_data[i] = msb ^ in_data[i];
         s           = {s[SW-2:0], scr_data[i]} ^ ({SW{msb}} & TAP_MASK);
      end
      next_state = s;
   end

endmodule

// File: rtl/scr_frame_ctrl.sv
// Frame controller: owns the LFSR state, accepts words, emits scrambled words through a 2-entry skid buffer.
// Build option: SCR_BYPASS_EN adds a bypass input (pass data through, freeze LFSR).
module scr_frame_ctrl
   import scr_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [SW-1:0]    seed,
   input  logic             seed_load,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NB-1:0]    in_data,
   input  logic             in_eof,
`ifdef SCR_BYPASS_EN
   input  logic             bypass,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NB-1:0]    out_data,
   output logic             out_sof,
   output logic             out_eof,
   output logic [SW-1:0]    state_out,
   output logic [CNT_W-1:0] word_cnt,
   output logic             busy,
   output logic             seed_err
);

   fsm_t          fsm, fsm_nxt;
   logic [SW-1:0] lfsr;
   logic [SW-1:0] step_state;
   logic [NB-1:0] step_data;
   word_t         ent0, ent1, push_word;
   logic          v0, v1, v0_nxt, v1_nxt;
   logic          sof_pend;
   logic          accept, pop, byp;
   logic          seed_err_nxt;

`ifdef SCR_BYPASS_EN
   assign byp = bypass;
`else
   assign byp = 1'b0;
`endif

   scr_step_nb u_step (
      .state      (lfsr),
      .in_data    (in_data),
      .next_state (step_state),
      .scr_data   (step_data)
   );

   assign accept    = (fsm == RUN) && in_ready && in_valid;
   assign pop       = v0 && out_ready;
   assign push_word = '{data: (byp ? in_data : step_data), sof: sof_pend, eof: in_eof};

   assign out_valid = v0;
   assign out_data  = ent0.data;
   assign out_sof   = ent0.sof;
   assign out_eof   = ent0.eof;
   assign state_out = lfsr;

   always_ff @(posedge clk) begin
      if (rst) fsm <= IDLE;
      else     fsm <= fsm_nxt;
   end

   // Next state plus next skid occupancy (pop shifts, push fills the first free slot)
   always_comb begin
      fsm_nxt      = fsm;
      seed_err_nxt = 1'b0;
      v0_nxt       = v0;
      v1_nxt       = v1;
      if (pop) begin
         v0_nxt = v1;
         v1_nxt = 1'b0;
      end
      if (accept) begin
         if (v0_nxt) v1_nxt = 1'b1;
         else        v0_nxt = 1'b1;
      end
      case (fsm)
         IDLE: begin
            if (seed_load) fsm_nxt = RUN;
         end
         RUN: begin
            seed_err_nxt = seed_load;
            if (accept && in_eof) fsm_nxt = DRAIN;
         end
         DRAIN: begin
            seed_err_nxt = seed_load;
            if (!v0_nxt) fsm_nxt = IDLE;
         end
         default: fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr     <= SEED_RST;
         word_cnt <= '0;
         sof_pend <= 1'b0;
         v0       <= 1'b0;
         v1       <= 1'b0;
         ent0     <= '0;
         ent1     <= '0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         seed_err <= 1'b0;
      end else begin
         v0       <= v0_nxt;
         v1       <= v1_nxt;
         in_ready <= (fsm_nxt == RUN) && !v1_nxt;
         busy     <= (fsm_nxt != IDLE);
         seed_err <= seed_err_nxt;
         if (fsm == IDLE && seed_load) begin
            lfsr     <= seed;
            word_cnt <= '0;
            sof_pend <= 1'b1;
         end
         if (accept) begin
            if (!byp) lfsr <= step_state;
            if (word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
            sof_pend <= 1'b0;
         end
         if (pop) ent0 <= ent1;
         // Accept implies slot 1 is free, so a push lands in slot 1 only if slot 0 stays occupied
         if (accept) begin
            if (v0 && !pop) ent1 <= push_word;
            else            ent0 <= push_word;
         end
      end
   end

endmodule

// File: tb/tb_scr_frame_ctrl.sv
// Directed and randomized-handshake checks of scr_frame_ctrl against a bit-serial scrambler model.
module tb_scr_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [69:0] seed = '0;
   logic        seed_load = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_data = '0;
   logic        in_eof = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [11:0] out_data;
   logic        out_sof;
   logic        out_eof;
   logic [69:0] state_out;
   logic [15:0] word_cnt;
   logic        busy;
   logic        seed_err;
`ifdef SCR_BYPASS_EN
   logic        bypass = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [69:0] SEED_RST_EXP = {70{1'b1}};

   always #5 clk = ~clk;

   scr_frame_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .seed      (seed),
      .seed_load (seed_load),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_eof    (in_eof),
`ifdef SCR_BYPASS_EN
      .bypass    (bypass),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sof   (out_sof),
      .out_eof   (out_eof),
      .state_out (state_out),
      .word_cnt  (word_cnt),
      .busy      (busy),
      .seed_err  (seed_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Bit-serial reference: one LFSR step per input bit, taps written out individually
   function automatic void model_word(input logic [69:0] s, input logic [11:0] d,
                                      output logic [69:0] so, output logic [11:0] o);
      logic [69:0] n;
      logic        m;
      o = '0;
      for (int i = 0; i < 12; i++) begin
         m     = s[69];
         n     = s << 1;
         n[0]  = m ^ d[i];
         n[30] = m ^ s[29];
         n[34] = m ^ s[33];
         n[43] = m ^ s[42];
         n[58] = m ^ s[57];
         n[63] = m ^ s[62];
         o[i]  = m ^ d[i];
         s     = n;
      end
      so = s;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      seed_load = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      checks++; if (seed_err !== 1'b0) begin errors++; $display("FAIL reset_seed_err got %b exp 0", seed_err); end
      checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL reset_word_cnt got %0d exp 0", word_cnt); end
      checks++; if (state_out !== SEED_RST_EXP) begin errors++; $display("FAIL reset_state got %h exp %h", state_out, SEED_RST_EXP); end
      checks++; if ({out_sof, out_eof} !== 2'b00) begin errors++; $display("FAIL reset_sof_eof got %b exp 00", {out_sof, out_eof}); end
      rst = 1'b0;
      seed_load = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_zero_seed;
      seed = '0;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy got %b exp 1", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready got %b exp 1", in_ready); end
      checks++; if (state_out !== 70'd0) begin errors++; $display("FAIL zero_seeded got %h exp 0", state_out); end
      out_ready = 1'b1;
      for (int w = 0; w < 4; w++) begin
         in_valid = 1'b1;
         in_data  = 12'h000;
         in_eof   = (w == 3);
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid w%0d got %b exp 1", w, out_valid); end
         checks++; if (out_data !== 12'h000) begin errors++; $display("FAIL zero_data w%0d got %h exp 000", w, out_data); end
         checks++; if (out_sof !== (w == 0)) begin errors++; $display("FAIL zero_sof w%0d got %b exp %b", w, out_sof, (w == 0)); end
         checks++; if (out_eof !== (w == 3)) begin errors++; $display("FAIL zero_eof w%0d got %b exp %b", w, out_eof, (w == 3)); end
         checks++; if (word_cnt !== 16'(w + 1)) begin errors++; $display("FAIL zero_cnt w%0d got %0d exp %0d", w, word_cnt, w + 1); end
         checks++; if (state_out !== 70'd0) begin errors++; $display("FAIL zero_state w%0d got %h exp 0", w, state_out); end
      end
      in_valid = 1'b0;
      in_eof   = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_drain_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_drain_busy got %b exp 0", busy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_idle_ready got %b exp 0", in_ready); end
   endtask

   task automatic test_single_word(input logic [11:0] d, input logic [11:0] exp_out);
      logic [69:0] ms;
      logic [11:0] mo;
      seed = 70'd1 << 69;
      model_word(seed, d, ms, mo);
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      in_eof    = 1'b1;
      tick();
      in_valid = 1'b0;
      in_eof   = 1'b0;
      checks++; if (out_data !== exp_out) begin errors++; $display("FAIL single_data %h got %h exp %h", d, out_data, exp_out); end
      checks++; if ({out_valid, out_sof, out_eof} !== 3'b111) begin errors++; $display("FAIL single_flags %h got %b exp 111", d, {out_valid, out_sof, out_eof}); end
      checks++; if (word_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt %h got %0d exp 1", d, word_cnt); end
      checks++; if (state_out !== ms) begin errors++; $display("FAIL single_state %h got %h exp %h", d, state_out, ms); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle %h got %b exp 0", d, busy); end
      checks++; if (state_out !== ms) begin errors++; $display("FAIL single_hold %h got %h exp %h", d, state_out, ms); end
   endtask

   task automatic test_random_frame;
      logic [69:0] ms, ns;
      logic [11:0] mo;
      logic [13:0] expq[$];
      logic        acc, pop;
      int          sent, rcv, cnt, cyc;
      ms = {6'($urandom), $urandom, $urandom};
      seed = ms;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      sent = 0; rcv = 0; cnt = 0; cyc = 0;
      while ((rcv < 100 || busy) && cyc < 3000) begin
         in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
         in_data   = 12'($urandom);
         in_eof    = (sent == 99);
         out_ready = 1'($urandom_range(0, 1));
         acc = in_valid && in_ready;
         pop = out_valid && out_ready;
         if (pop) begin
            checks++;
            if (expq.size() == 0) begin
               errors++; $display("FAIL rand_extra word got %h exp none", out_data);
            end else begin
               if ({out_data, out_sof, out_eof} !== expq[0]) begin
                  errors++; $display("FAIL rand_word %0d got %h exp %h", rcv, {out_data, out_sof, out_eof}, expq[0]);
               end
               void'(expq.pop_front());
            end
            rcv++;
            cnt--;
         end
         if (acc) begin
            model_word(ms, in_data, ns, mo);
            ms = ns;
            expq.push_back({mo, (sent == 0), (sent == 99)});
            sent++;
            cnt++;
         end
         tick();
         cyc++;
         checks++;
         if (out_valid !== (cnt != 0) || cnt > 2) begin
            errors++; $display("FAIL rand_occupancy cyc %0d got valid %b exp count %0d", cyc, out_valid, cnt);
         end
      end
      in_valid = 1'b0;
      in_eof   = 1'b0;
      checks++; if (rcv != 100 || sent != 100) begin errors++; $display("FAIL rand_count got rx %0d tx %0d exp 100", rcv, sent); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_timeout got busy %b exp 0", busy); end
      checks++; if (word_cnt !== 16'd100) begin errors++; $display("FAIL rand_word_cnt got %0d exp 100", word_cnt); end
      checks++; if (state_out !== ms) begin errors++; $display("FAIL rand_state got %h exp %h", state_out, ms); end
   endtask

   task automatic test_seed_err;
      logic [69:0] s0, ms, ns;
      logic [11:0] mo;
      s0 = 70'h2A_5A5A_1234_5678_9ABC;
      ms = s0;
      seed = s0;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 12'h5A3;
      model_word(ms, in_data, ns, mo); ms = ns;
      tick();
      checks++; if (out_data !== mo) begin errors++; $display("FAIL serr_w0 got %h exp %h", out_data, mo); end
      checks++; if (seed_err !== 1'b0) begin errors++; $display("FAIL serr_quiet got %b exp 0", seed_err); end
      in_data   = 12'h0F1;
      seed      = ~s0;
      seed_load = 1'b1;
      model_word(ms, in_data, ns, mo); ms = ns;
      tick();
      seed_load = 1'b0;
      checks++; if (out_data !== mo) begin errors++; $display("FAIL serr_w1 got %h exp %h", out_data, mo); end
      checks++; if (seed_err !== 1'b1) begin errors++; $display("FAIL serr_pulse got %b exp 1", seed_err); end
      checks++; if (state_out !== ms) begin errors++; $display("FAIL serr_state got %h exp %h", state_out, ms); end
      in_data = 12'hC3C;
      in_eof  = 1'b1;
      model_word(ms, in_data, ns, mo); ms = ns;
      tick();
      in_valid = 1'b0;
      in_eof   = 1'b0;
      checks++; if (seed_err !== 1'b0) begin errors++; $display("FAIL serr_one_cycle got %b exp 0", seed_err); end
      checks++; if ({out_data, out_sof, out_eof} !== {mo, 2'b01}) begin errors++; $display("FAIL serr_w2 got %h exp %h", {out_data, out_sof, out_eof}, {mo, 2'b01}); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL serr_idle got %b exp 0", busy); end
      checks++; if (state_out !== ms) begin errors++; $display("FAIL serr_final got %h exp %h", state_out, ms); end
   endtask

   task automatic test_rst_mid_frame;
      seed = 70'h01_2345_6789_ABCD_EF01;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 12'h111;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstm_one_ready got %b exp 1", in_ready); end
      in_data = 12'h222;
      tick();
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstm_full_ready got %b exp 0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstm_full_valid got %b exp 1", out_valid); end
      checks++; if (word_cnt !== 16'd2) begin errors++; $display("FAIL rstm_cnt got %0d exp 2", word_cnt); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstm_busy got %b exp 0", busy); end
      checks++; if (state_out !== SEED_RST_EXP) begin errors++; $display("FAIL rstm_state got %h exp %h", state_out, SEED_RST_EXP); end
      checks++; if (word_cnt !== 16'd0) begin errors++; $display("FAIL rstm_cnt0 got %0d exp 0", word_cnt); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_discard got %b exp 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_zero_seed();
      test_single_word(12'h000, 12'h081);
      test_single_word(12'hFFF, 12'hF7E);
      test_random_frame();
      test_seed_err();
      test_rst_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
